// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider with FREE/BYZERO/ON/END control.
// Define DIV_SIGNED_EN to honour signed_div; otherwise every divide is unsigned.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        start,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic [63:0] res_q, res_d;

    logic        load;
    logic        last;
    logic [33:0] trial;
    logic        qbit;
    logic [31:0] rem_n;
    logic [31:0] quo_n;
    logic [31:0] rem_fix;
    logic [31:0] quo_fix;

`ifdef DIV_SIGNED_EN
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        neg1;
    logic        neg2;
`else
    logic        unused_signed;
`endif

    assign load = (state_q == FREE) && start && !annul;
    assign last = (cnt_q == 5'd31);

    // dvd_q shifts its bits out at the top and collects quotient bits at the bottom
    assign trial = {1'b0, rem_q, dvd_q[31]} - {2'b00, dvs_q};
    assign qbit  = ~trial[33];
    assign rem_n = qbit ? trial[31:0] : {rem_q[30:0], dvd_q[31]};
    assign quo_n = {dvd_q[30:0], qbit};

`ifdef DIV_SIGNED_EN
    assign neg1    = signed_div && opdata1[31];
    assign neg2    = signed_div && opdata2[31];
    assign quo_fix = negq_q ? (~quo_n + 32'd1) : quo_n;
    assign rem_fix = negr_q ? (~rem_n + 32'd1) : rem_n;
`else
    assign unused_signed = signed_div;
    assign quo_fix = quo_n;
    assign rem_fix = rem_n;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FREE;
            cnt_q   <= 5'd0;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            rem_q   <= 32'd0;
            res_q   <= 64'd0;
`ifdef DIV_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
`ifdef DIV_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FREE: begin
                if (load) begin
                    state_d = (opdata2 == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                state_d = annul ? FREE : END;
            end
            ON: begin
                if (annul) begin
                    state_d = FREE;
                end else if (last) begin
                    state_d = END;
                end
            end
            END: begin
                if (!start) begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        res_d  = 64'd0;
`ifdef DIV_SIGNED_EN
        negq_d = negq_q;
        negr_d = negr_q;
`endif
        unique case (state_q)
            FREE: begin
                if (load) begin
                    cnt_d  = 5'd0;
                    rem_d  = 32'd0;
`ifdef DIV_SIGNED_EN
                    dvd_d  = neg1 ? (~opdata1 + 32'd1) : opdata1;
                    dvs_d  = neg2 ? (~opdata2 + 32'd1) : opdata2;
                    negq_d = neg1 ^ neg2;
                    negr_d = neg1;
`else
                    dvd_d  = opdata1;
                    dvs_d  = opdata2;
`endif
                end
            end
            ON: begin
                if (!annul) begin
                    cnt_d = cnt_q + 5'd1;
                    dvd_d = quo_n;
                    rem_d = rem_n;
                    if (last) begin
                        res_d = {rem_fix, quo_fix};
                    end
                end
            end
            END: begin
                if (start) begin
                    res_d = res_q;
                end
            end
            default: begin
                res_d = 64'd0;
            end
        endcase
    end

    always_comb begin
        ready  = (state_q == END);
        result = res_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomised self-checking bench for div_unit against an arithmetic reference.
// Build with DIV_SIGNED_EN to match a signed-enabled design build.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = 32'd0;
    logic [31:0] opdata2 = 32'd0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    bit          chk_en = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_left = 0;
    logic [63:0] m_res  = 64'd0;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] uq;
        logic [31:0] ur;
        if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
        if (s) begin
            longint sa;
            longint sb;
            longint q;
            longint r;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
`else
        if (s) begin
            uq = a / b;
        end
`endif
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: result appears 32 edges after the load (1 edge for a zero divisor),
    // held while start stays high; annul cancels only while computing.
    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_res  = 64'd0;
        end else if (m_done) begin
            if (!start) m_done = 1'b0;
        end else if (m_busy) begin
            if (annul) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (start && !annul) begin
            m_busy = 1'b1;
            m_left = (opdata2 == 32'd0) ? 1 : 32;
            m_res  = ref_div(opdata1, opdata2, signed_div);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", {63'd0, ready}, {63'd0, m_done});
            chk("cyc_result", result, m_done ? m_res : 64'd0);
        end
    end

    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            opdata1 = $urandom;
            opdata2 = $urandom;
            signed_div = 1'($urandom);
        end while (!ready && lat < 100);
        if (!ready) chk("ready_timeout", {63'd0, ready}, 64'd1);
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [63:0] res, output int lat);
        opdata1 = a;
        opdata2 = b;
        signed_div = s;
        start = 1'b1;
        annul = 1'b0;
        @(posedge clk);
        #1;
        wait_ready(lat);
        res = result;
    endtask

    task automatic drop_start();
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_ready", {63'd0, ready}, 64'd0);
        chk("drop_result", result, 64'd0);
    endtask

    initial begin
        logic [63:0] r;
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          k;

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_result", result, 64'd0);

        chk("ref_100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
        chk("ref_5_0", ref_div(32'd5, 32'd0, 1'b0), 64'h0);
        chk("ref_9_3", ref_div(32'd9, 32'd3, 1'b0), 64'h00000000_00000003);
`ifdef DIV_SIGNED_EN
        chk("ref_m7_2", ref_div(32'hFFFFFFF9, 32'h2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);
        chk("ref_min_m1", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), 64'h00000000_80000000);
`else
        chk("ref_m7_2", ref_div(32'hFFFFFFF9, 32'h2, 1'b1), 64'h00000001_7FFFFFFC);
        chk("ref_min_m1", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), 64'h80000000_00000000);
`endif
        rst = 1'b1;

        do_div(32'd100, 32'd7, 1'b0, r, lat);
        chk("d100_7_res", r, 64'h00000002_0000000E);
        chk("d100_7_lat", 64'(lat), 64'd32);
        drop_start();

        do_div(32'hFFFFFFF9, 32'h2, 1'b1, r, lat);
`ifdef DIV_SIGNED_EN
        chk("m7_2_res", r, 64'hFFFFFFFF_FFFFFFFD);
`else
        chk("m7_2_res", r, 64'h00000001_7FFFFFFC);
`endif
        drop_start();

        do_div(32'd5, 32'd0, 1'b0, r, lat);
        chk("d5_0_res", r, 64'h0);
        chk("d5_0_lat", 64'(lat), 64'd1);
        drop_start();

        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, r, lat);
`ifdef DIV_SIGNED_EN
        chk("min_m1_res", r, 64'h00000000_80000000);
`else
        chk("min_m1_res", r, 64'h80000000_00000000);
`endif
        drop_start();

        // Annul during iteration 10 of 1000/3
        opdata1 = 32'd1000;
        opdata2 = 32'd3;
        signed_div = 1'b0;
        start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        annul = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("annul_ready", {63'd0, ready}, 64'd0);
        do_div(32'd9, 32'd3, 1'b0, r, lat);
        chk("d9_3_res", r, 64'h00000000_00000003);
        chk("d9_3_lat", 64'(lat), 64'd32);
        drop_start();

        // Reset during iteration 20 with start held high throughout
        opdata1 = 32'd1000;
        opdata2 = 32'd7;
        start = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ready", {63'd0, ready}, 64'd0);
        chk("midrst_result", result, 64'd0);
        rst = 1'b1;
        opdata1 = 32'd12345;
        opdata2 = 32'd10;
        @(posedge clk);
        #1;
        wait_ready(lat);
        chk("postrst_res", result, 64'h00000005_000004D2);
        chk("postrst_lat", 64'(lat), 64'd32);
        drop_start();

        // start together with annul in FREE must not launch
        start = 1'b1;
        annul = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("start_annul", {63'd0, ready}, 64'd0);
        start = 1'b0;
        annul = 1'b0;
        @(posedge clk);
        #1;

        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            k = $urandom_range(0, 7);
            if (k == 0) b = 32'd0;
            else if (k < 3) b = 32'($urandom_range(1, 20));
            else if (k == 3) b = 32'hFFFFFFFF;
            else b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            s = 1'($urandom);
            if (b != 32'd0 && $urandom_range(0, 4) == 0) begin
                opdata1 = a;
                opdata2 = b;
                signed_div = s;
                start = 1'b1;
                @(posedge clk);
                repeat ($urandom_range(0, 30)) @(posedge clk);
                #1;
                annul = 1'b1;
                start = 1'b0;
                @(posedge clk);
                #1;
                annul = 1'b0;
            end else begin
                do_div(a, b, s, r, lat);
                chk("rnd_res", r, ref_div(a, b, s));
                chk("rnd_lat", 64'(lat), (b == 32'd0) ? 64'd1 : 64'd32);
                repeat ($urandom_range(0, 3)) begin
                    annul = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
                annul = 1'b0;
                drop_start();
            end
            repeat ($urandom_range(0, 2)) begin
                annul = 1'($urandom);
                @(posedge clk);
                #1;
            end
            annul = 1'b0;
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL provide port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL provide port rst, input, 1, synchronous active-low reset (0 = reset), sampled on rising clk edge.
REQ-003 SHALL provide port signed_div, input, 1, 1 = two's-complement divide (DIV), 0 = unsigned (DIVU).
REQ-004 SHALL provide port opdata1, input, 32, dividend from EX stage.
REQ-005 SHALL provide port opdata2, input, 32, divisor from EX stage.
REQ-006 SHALL provide port start, input, 1, request; EX holds it high, with operands stable, until ready is seen.
REQ-007 SHALL provide port annul, input, 1, cancel in-flight divide (flush).
REQ-008 SHALL provide port result, output, 64, {remainder[63:32], quotient[31:0]}, HI/LO order.
REQ-009 SHALL provide port ready, output, 1, result valid; EX uses !ready && start as its stall request to ctrl.

Function
REQ-010 SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-011 In FREE, start=1 and annul=0 SHALL load operands and go to BYZERO if opdata2==0, else ON with iteration count 0.
REQ-012 In FREE, start=0 or annul=1 SHALL stay in FREE with ready=0 and result=0.
REQ-013 ON SHALL perform one restoring radix-2 step per cycle: 33-bit trial subtract of divisor from {partial remainder, next dividend bit}; quotient bit = 1 if non-negative.
REQ-014 ON SHALL run exactly 32 iterations; the edge performing the 32nd SHALL enter END and register result with ready=1 (ready high 32 edges after the load edge).
REQ-015 BYZERO SHALL enter END on the next edge with result=64'h0 and ready=1.
REQ-016 In ON or BYZERO, annul=1 SHALL return to FREE on that edge; ready SHALL stay 0 and result SHALL stay 0.
REQ-017 In END, start=1 SHALL hold state, ready=1 and result; start=0 SHALL go to FREE with ready=0 and result=0 on that edge. annul SHALL be ignored in END.
REQ-018 For a signed divide, a negative operand SHALL be converted to its magnitude at load. The quotient SHALL be negated when operand signs differ. The remainder SHALL take the dividend's sign.
REQ-019 Dividend 32'h80000000 / divisor 32'hFFFFFFFF signed SHALL produce quotient 32'h80000000, remainder 0 (wrap, no trap).
REQ-020 Operand changes while not in FREE SHALL have no effect; operands SHALL be sampled only at the load edge.

Reset
REQ-021 rst=0 at a rising edge SHALL force state FREE, iteration count 0, ready=0, result=64'h0, internal operands 0, from any state including mid-ON.
REQ-022 The first start after reset release SHALL be accepted normally.

Configuration
REQ-023 With DIV_SIGNED_EN defined, signed_div SHALL be honoured per REQ-018/019.
REQ-024 Without DIV_SIGNED_EN, signed_div SHALL be ignored, all divides SHALL be unsigned, and no negation logic SHALL be synthesised.

Verification
REQ-025 Unsigned divide 100/7, start held high: result=64'h00000002_0000000E; ready rises 32 edges after load; clearing start the next cycle gives ready=0.
REQ-026 Signed divide (DIV_SIGNED_EN) -7/2, i.e. 32'hFFFFFFF9/32'h2: result=64'hFFFFFFFF_FFFFFFFD. The same stimulus without the macro: result=64'h00000001_7FFFFFFC.
REQ-027 Divide by zero, 5/0: BYZERO, then END one edge later with ready=1 and result=0.
REQ-028 annul=1 during iteration 10 of 1000/3: state returns to FREE and ready never asserts. A new 9/3 then yields 64'h00000000_00000003.
REQ-029 rst=0 during iteration 20: all outputs 0 next edge, state FREE. start held high across the reset then begins a fresh 32-iteration divide after release.
REQ-030 Signed 32'h80000000/32'hFFFFFFFF: result=64'h00000000_80000000.
